// File: rtl/gcm_ctr_gen_pkg.sv
// gcm_pkg: shared block width, FSM state type and counter-field increment helper
package gcm_pkg;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {CG_IDLE, CG_RUN} cg_state_t;

    // Adds n to the low ctr_w bits of a block modulo 2^ctr_w, leaving the IV field untouched
    function automatic logic [0:BLOCK_W-1] inc_ctr(
        input logic [0:BLOCK_W-1] blk,
        input logic [31:0]        n,
        input int                 ctr_w
    );
        logic [0:BLOCK_W-1] m;
        m = (BLOCK_W'(1) << ctr_w) - BLOCK_W'(1);
        return (blk & ~m) | ((blk + BLOCK_W'(n)) & m);
    endfunction
endpackage

// File: rtl/gcm_ctr_gen_lane.sv
// gcm_ctr_lane: combinational counter block for lane K, {iv, ctr+K} with inc32-style wrap
module gcm_ctr_lane
    import gcm_pkg::*;
#(
    parameter int CTR_W = 32,
    parameter int K     = 0
) (
    input  logic [0:BLOCK_W-1] base_i,
    output logic [0:BLOCK_W-1] blk_o
);
    assign blk_o = inc_ctr(base_i, 32'(K), CTR_W);
endmodule

// File: rtl/gcm_ctr_gen.sv
// gcm_ctr_gen: GCM J0 and multi-lane counter-block generator with backpressure and abort
module gcm_ctr_gen
    import gcm_pkg::*;
#(
    parameter int IV_W  = 96,
    parameter int CTR_W = 32,
    parameter int LANES = 1,
    parameter int LEN_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start_valid,
    output logic                     o_start_ready,
    input  logic [0:IV_W-1]          i_iv,
    input  logic [0:LEN_W-1]         i_nblocks,
    input  logic                     i_abort,
    output logic [0:BLOCK_W-1]       o_j0,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [0:LANES*BLOCK_W-1] o_cb,
    output logic [LANES-1:0]         o_lane_mask,
    output logic                     o_last,
    output logic                     o_done
);
    if (IV_W + CTR_W != BLOCK_W) begin : g_bad_width
        $error("gcm_ctr_gen: IV_W + CTR_W must equal 128");
    end
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("gcm_ctr_gen: LANES must be 1..8");
    end

    cg_state_t                 state_q, state_d;
    logic [0:IV_W-1]           iv_q, iv_d;
    logic [CTR_W-1:0]          ctr_q, ctr_d;
    logic [LEN_W-1:0]          rem_q, rem_d;
    logic [0:BLOCK_W-1]        j0_q, j0_d;
    logic [0:LANES*BLOCK_W-1]  cb_q, cb_d;
    logic [LANES-1:0]          mask_q, mask_d;
    logic                      last_q, last_d;
    logic                      valid_q, done_q, done_d, ready_q;
    logic [0:BLOCK_W-1]        base_d;

    assign o_start_ready = ready_q;
    assign o_j0          = j0_q;
    assign o_valid       = valid_q;
    assign o_cb          = cb_q;
    assign o_lane_mask   = mask_q;
    assign o_last        = last_q;
    assign o_done        = done_q;

    // Abort overrides everything; a zero-length descriptor only refreshes J0 and reports done
    always_comb begin
        state_d = state_q;
        iv_d    = iv_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        j0_d    = j0_q;
        done_d  = 1'b0;
        if (i_abort) begin
            state_d = CG_IDLE;
        end else if (state_q == CG_IDLE && i_start_valid && ready_q) begin
            iv_d    = i_iv;
            ctr_d   = CTR_W'(2);
            rem_d   = i_nblocks;
            j0_d    = {i_iv, CTR_W'(1)};
            state_d = (i_nblocks != '0) ? CG_RUN : CG_IDLE;
            done_d  = (i_nblocks == '0);
        end else if (state_q == CG_RUN && i_ready) begin
            state_d = last_q ? CG_IDLE : CG_RUN;
            done_d  = last_q;
            ctr_d   = ctr_q + CTR_W'(LANES);
            rem_d   = rem_q - LEN_W'(LANES);
        end
    end

    // Beat attributes are precomputed from next state so every output leaves a flop
    always_comb begin
        mask_d = '0;
        for (int k = 0; k < LANES; k++) mask_d[k] = LEN_W'(k) < rem_d;
        last_d = rem_d <= LEN_W'(LANES);
    end

    assign base_d = {iv_d, ctr_d};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gcm_ctr_lane #(.CTR_W(CTR_W), .K(k)) u_lane (
            .base_i (base_d),
            .blk_o  (cb_d[k*BLOCK_W +: BLOCK_W])
        );
    end

    // State and output registers; start_ready stays low for the reset cycle itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CG_IDLE;
            iv_q    <= '0;
            ctr_q   <= '0;
            rem_q   <= '0;
            j0_q    <= '0;
            cb_q    <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iv_q    <= iv_d;
            ctr_q   <= ctr_d;
            rem_q   <= rem_d;
            j0_q    <= j0_d;
            cb_q    <= cb_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            valid_q <= state_d == CG_RUN;
            done_q  <= done_d;
            ready_q <= state_d == CG_IDLE;
        end
    end
endmodule

// File: tb/tb_gcm_ctr_gen.sv
// tb_gcm_ctr_gen: three configurations checked every cycle against a message-level model plus literal spot checks
module tb_gcm_ctr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         sv  [3] = '{1'b0, 1'b0, 1'b0};
    logic         rdy [3] = '{1'b1, 1'b1, 1'b1};
    logic         ab  [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] iv  [3] = '{128'd0, 128'd0, 128'd0};
    logic [31:0]  nb  [3] = '{32'd0, 32'd0, 32'd0};

    logic [511:0] cb  [3];
    logic [7:0]   msk [3];
    logic [127:0] j0  [3];
    logic         vld [3], lst [3], dn [3], srdy [3];

    logic [0:127] cb0;
    logic [0:511] cb1;
    logic [0:255] cb2;
    logic [0:0]   m0;
    logic [3:0]   m1;
    logic [1:0]   m2;
    assign cb[0]  = 512'(cb0);
    assign cb[1]  = 512'(cb1);
    assign cb[2]  = 512'(cb2);
    assign msk[0] = 8'(m0);
    assign msk[1] = 8'(m1);
    assign msk[2] = 8'(m2);

    gcm_ctr_gen #(.IV_W(96), .CTR_W(32), .LANES(1), .LEN_W(32)) u_d0 (
        .clk(clk), .rst(rst), .i_start_valid(sv[0]), .o_start_ready(srdy[0]),
        .i_iv(iv[0][95:0]), .i_nblocks(nb[0]), .i_abort(ab[0]), .o_j0(j0[0]),
        .o_valid(vld[0]), .i_ready(rdy[0]), .o_cb(cb0), .o_lane_mask(m0),
        .o_last(lst[0]), .o_done(dn[0]));

    gcm_ctr_gen #(.IV_W(96), .CTR_W(32), .LANES(4), .LEN_W(32)) u_d1 (
        .clk(clk), .rst(rst), .i_start_valid(sv[1]), .o_start_ready(srdy[1]),
        .i_iv(iv[1][95:0]), .i_nblocks(nb[1]), .i_abort(ab[1]), .o_j0(j0[1]),
        .o_valid(vld[1]), .i_ready(rdy[1]), .o_cb(cb1), .o_lane_mask(m1),
        .o_last(lst[1]), .o_done(dn[1]));

    gcm_ctr_gen #(.IV_W(120), .CTR_W(8), .LANES(2), .LEN_W(32)) u_d2 (
        .clk(clk), .rst(rst), .i_start_valid(sv[2]), .o_start_ready(srdy[2]),
        .i_iv(iv[2][119:0]), .i_nblocks(nb[2]), .i_abort(ab[2]), .o_j0(j0[2]),
        .o_valid(vld[2]), .i_ready(rdy[2]), .o_cb(cb2), .o_lane_mask(m2),
        .o_last(lst[2]), .o_done(dn[2]));

    int checks   = 0;
    int failures = 0;

    task automatic eq(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int lanes_of(input int d);
        return d == 0 ? 1 : d == 1 ? 4 : 2;
    endfunction

    function automatic int cw_of(input int d);
        return d == 2 ? 8 : 32;
    endfunction

    // Beat b of a message: lane k holds the IV over counter (2 + b*L + k) mod 2^w, lane 0 most significant
    function automatic logic [511:0] exp_cb(input int d, input logic [127:0] v, input int b);
        logic [511:0] r;
        int l, w;
        longint c;
        r = '0;
        l = lanes_of(d);
        w = cw_of(d);
        for (int k = 0; k < l; k++) begin
            c = longint'(2 + b * l + k) % (longint'(1) << w);
            r[(l-1-k)*128 +: 128] = (v << w) | 128'(c);
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_mask(input int l, input int rem);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < l; k++) m[k] = k < rem;
        return m;
    endfunction

    logic         busy  [3] = '{1'b0, 1'b0, 1'b0};
    logic         edone [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] ej0   [3] = '{128'd0, 128'd0, 128'd0};
    logic [127:0] miv   [3];
    int           mn    [3];
    int           mb    [3];
    logic         inrst = 1'b1;

    // Compare what the last edge produced, then advance the model with the inputs the next edge will see
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int l, rem;
            l   = lanes_of(d);
            rem = mn[d] - mb[d] * l;
            eq($sformatf("valid%0d", d), 512'(vld[d]), 512'(busy[d]));
            eq($sformatf("start_ready%0d", d), 512'(srdy[d]), 512'(!inrst && !busy[d]));
            eq($sformatf("done%0d", d), 512'(dn[d]), 512'(edone[d]));
            eq($sformatf("j0_%0d", d), 512'(j0[d]), 512'(ej0[d]));
            if (busy[d]) begin
                eq($sformatf("cb%0d beat%0d", d, mb[d]), cb[d], exp_cb(d, miv[d], mb[d]));
                eq($sformatf("mask%0d beat%0d", d, mb[d]), 512'(msk[d]), 512'(exp_mask(l, rem)));
                eq($sformatf("last%0d beat%0d", d, mb[d]), 512'(lst[d]), 512'(rem <= l));
            end
            if (rst) begin
                busy[d]  = 1'b0;
                edone[d] = 1'b0;
                ej0[d]   = '0;
            end else begin
                edone[d] = 1'b0;
                if (ab[d]) begin
                    busy[d] = 1'b0;
                end else if (busy[d] && rdy[d]) begin
                    if (rem <= l) begin
                        busy[d]  = 1'b0;
                        edone[d] = 1'b1;
                    end else begin
                        mb[d]++;
                    end
                end else if (!busy[d] && !inrst && sv[d]) begin
                    miv[d] = iv[d];
                    mn[d]  = int'(nb[d]);
                    mb[d]  = 0;
                    ej0[d] = (iv[d] << cw_of(d)) | 128'd1;
                    if (nb[d] == 0) edone[d] = 1'b1;
                    else busy[d] = 1'b1;
                end
            end
        end
        inrst = rst;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input logic [127:0] v, input int n);
        sv[d] = 1'b1;
        iv[d] = v;
        nb[d] = 32'(n);
        cyc();
        sv[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((vld[d] || !srdy[d]) && n < 600) begin
            cyc();
            n++;
        end
        eq($sformatf("idle_timeout%0d", d), 512'(n < 600), 512'(1));
    endtask

    localparam logic [95:0]  IV_A = 96'hCAFEBABE_00000000_00000001;
    localparam logic [95:0]  IV_B = 96'h01234567_89ABCDEF_FEDCBA98;
    localparam logic [119:0] IV_C = 120'h00112233445566778899AABBCCDDEE;

    int  exp3 [5] = '{3, 3, 3, 4, 5};
    logic rp3 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        cyc();
        cyc();
        for (int d = 0; d < 3; d++) begin
            eq($sformatf("rst valid%0d", d), 512'(vld[d]), 512'(0));
            eq($sformatf("rst ready%0d", d), 512'(srdy[d]), 512'(0));
            eq($sformatf("rst cb%0d", d), cb[d], 512'(0));
            eq($sformatf("rst mask%0d", d), 512'(msk[d]), 512'(0));
            eq($sformatf("rst last%0d", d), 512'(lst[d]), 512'(0));
            eq($sformatf("rst done%0d", d), 512'(dn[d]), 512'(0));
            eq($sformatf("rst j0_%0d", d), 512'(j0[d]), 512'(0));
        end
        rst = 1'b0;
        cyc();
        eq("ready after rst", 512'(srdy[0]), 512'(1));

        start(0, 128'(IV_A), 3);
        eq("t1 j0 ctr", 512'(j0[0][31:0]), 512'(1));
        eq("t1 j0 iv", 512'(j0[0][127:32]), 512'(IV_A));
        for (int i = 0; i < 3; i++) begin
            eq($sformatf("t1 ctr beat%0d", i), 512'(cb[0][31:0]), 512'(2 + i));
            eq($sformatf("t1 last beat%0d", i), 512'(lst[0]), 512'(i == 2));
            cyc();
        end
        eq("t1 valid end", 512'(vld[0]), 512'(0));
        eq("t1 done", 512'(dn[0]), 512'(1));
        eq("t1 ready end", 512'(srdy[0]), 512'(1));
        cyc();
        eq("t1 done pulse", 512'(dn[0]), 512'(0));

        start(1, 128'(IV_B), 6);
        eq("t2 b0 lane0", 512'(cb[1][384 +: 32]), 512'(2));
        eq("t2 b0 lane3", 512'(cb[1][0 +: 32]), 512'(5));
        eq("t2 b0 mask", 512'(msk[1]), 512'(8'h0F));
        eq("t2 b0 last", 512'(lst[1]), 512'(0));
        cyc();
        eq("t2 b1 lane0", 512'(cb[1][384 +: 32]), 512'(6));
        eq("t2 b1 lane3", 512'(cb[1][0 +: 32]), 512'(9));
        eq("t2 b1 mask", 512'(msk[1]), 512'(8'h03));
        eq("t2 b1 last", 512'(lst[1]), 512'(1));
        cyc();
        eq("t2 done", 512'(dn[1]), 512'(1));

        start(0, 128'(IV_B), 4);
        for (int i = 0; i < 5; i++) begin
            rdy[0] = rp3[i];
            cyc();
            eq($sformatf("t3 ctr step%0d", i), 512'(cb[0][31:0]), 512'(exp3[i]));
        end
        rdy[0] = 1'b1;
        cyc();
        eq("t3 done", 512'(dn[0]), 512'(1));

        start(2, 128'(IV_C), 260);
        repeat (126) cyc();
        eq("t4 lane0 FE", 512'(cb[2][128 +: 8]), 512'(8'hFE));
        eq("t4 lane1 FF", 512'(cb[2][0 +: 8]), 512'(8'hFF));
        eq("t4 iv lane0", 512'(cb[2][255:136]), 512'(IV_C));
        cyc();
        eq("t4 lane0 00", 512'(cb[2][128 +: 8]), 512'(8'h00));
        eq("t4 lane1 01", 512'(cb[2][0 +: 8]), 512'(8'h01));
        eq("t4 iv lane1", 512'(cb[2][127:8]), 512'(IV_C));
        wait_idle(2);

        start(0, 128'(IV_A), 0);
        eq("t5 valid", 512'(vld[0]), 512'(0));
        eq("t5 done", 512'(dn[0]), 512'(1));
        eq("t5 j0", 512'(j0[0]), 512'({IV_A, 32'd1}));
        cyc();
        eq("t5 done pulse", 512'(dn[0]), 512'(0));

        start(0, 128'(IV_B), 5);
        cyc();
        eq("t6 beat1 ctr", 512'(cb[0][31:0]), 512'(3));
        ab[0] = 1'b1;
        cyc();
        ab[0] = 1'b0;
        eq("t6 abort valid", 512'(vld[0]), 512'(0));
        eq("t6 abort done", 512'(dn[0]), 512'(0));
        cyc();
        eq("t6 no done", 512'(dn[0]), 512'(0));
        eq("t6 ready", 512'(srdy[0]), 512'(1));
        start(0, 128'(IV_A), 2);
        eq("t6 restart ctr", 512'(cb[0][31:0]), 512'(2));
        wait_idle(0);

        sv[1] = 1'b1;
        ab[1] = 1'b1;
        nb[1] = 32'd3;
        cyc();
        sv[1] = 1'b0;
        ab[1] = 1'b0;
        eq("t6 idle abort valid", 512'(vld[1]), 512'(0));
        cyc();
        eq("t6 idle abort done", 512'(dn[1]), 512'(0));

        start(0, 128'(IV_B), 5);
        cyc();
        rst = 1'b1;
        cyc();
        eq("t6 rst valid", 512'(vld[0]), 512'(0));
        eq("t6 rst ready", 512'(srdy[0]), 512'(0));
        rst = 1'b0;
        cyc();
        eq("t6 rst no done", 512'(dn[0]), 512'(0));
        eq("t6 rst ready back", 512'(srdy[0]), 512'(1));
        start(0, 128'(IV_A), 1);
        eq("t6 rst restart ctr", 512'(cb[0][31:0]), 512'(2));
        eq("t6 rst restart last", 512'(lst[0]), 512'(1));
        cyc();
        eq("t6 rst restart done", 512'(dn[0]), 512'(1));
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
